// File: rtl/data_mem_controller_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
interface data_mem_controller_if;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_WriteData;
    logic [3:0]  DataMem_WriteEnable;
    logic        DataMem_Read;
    logic        DataMem_Write;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;

    modport master (
        output DataMem_Address, DataMem_WriteData, DataMem_WriteEnable,
               DataMem_Read, DataMem_Write,
        input  DataMem_In, DataMem_Ready
    );

    modport slave (
        input  DataMem_Address, DataMem_WriteData, DataMem_WriteEnable,
               DataMem_Read, DataMem_Write,
        output DataMem_In, DataMem_Ready
    );
endinterface

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: request/ready handshake, big-endian lane
// steering, load extension, alignment exceptions. LL/SC tracking under `DATAMEM_LLSC_EN.
module data_mem_controller (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_WriteData,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_Byte,
    input  logic        MEM_Half,
    input  logic        MEM_SignExtend,
    input  logic        MEM_LLSC,
    input  logic        IF_Stall,
    output logic        M_Stall_Controller,
    output logic [31:0] M_ReadData,
    output logic        M_Exc_AdEL,
    output logic        M_Exc_AdES,
    data_mem_controller_if.master dmem
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        request, misaligned, sc_fail, valid;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

`ifdef DATAMEM_LLSC_EN
    logic        ll_q, ll_d;
    logic [29:0] lladdr_q, lladdr_d;
    logic        ll_match;

    assign ll_match = ll_q & (lladdr_q == MEM_Address[31:2]);
    // Only judged in IDLE: after a successful SC the LL bit is already clear
    // while the same instruction still sits in MEM during DONE.
    assign sc_fail  = MEM_MemWrite & MEM_LLSC & ~ll_match & (state_q == IDLE);
`else
    assign sc_fail  = 1'b0;
`endif

    assign request    = MEM_MemRead | MEM_MemWrite;
    assign misaligned = (MEM_Half & ~MEM_Byte & MEM_Address[0]) |
                        (~MEM_Byte & ~MEM_Half & (MEM_Address[1:0] != 2'b00));
    assign valid      = request & ~misaligned & ~sc_fail;

    assign M_Exc_AdEL = MEM_MemRead & misaligned;
    assign M_Exc_AdES = MEM_MemWrite & misaligned;
    assign M_Stall_Controller = (valid & (state_q == IDLE)) | (state_q == ACCESS);
    assign M_ReadData = sc_fail ? '0 : rdata_q;

    assign dmem.DataMem_Address     = MEM_Address[31:2];
    assign dmem.DataMem_WriteData   = wdata_q;
    assign dmem.DataMem_WriteEnable = we_q;
    assign dmem.DataMem_Read        = read_q;
    assign dmem.DataMem_Write       = write_q;

    always_comb begin
        lane_we    = 4'b1111;
        lane_wdata = MEM_WriteData;
        if (MEM_Byte) begin
            lane_we    = 4'b1000 >> MEM_Address[1:0];
            lane_wdata = {4{MEM_WriteData[7:0]}};
        end else if (MEM_Half) begin
            lane_we    = MEM_Address[1] ? 4'b0011 : 4'b1100;
            lane_wdata = {2{MEM_WriteData[15:0]}};
        end
    end

    always_comb begin
        load_byte = 8'h00;
        case (MEM_Address[1:0])
            2'd0:    load_byte = dmem.DataMem_In[31:24];
            2'd1:    load_byte = dmem.DataMem_In[23:16];
            2'd2:    load_byte = dmem.DataMem_In[15:8];
            default: load_byte = dmem.DataMem_In[7:0];
        endcase
        load_half = MEM_Address[1] ? dmem.DataMem_In[15:0] : dmem.DataMem_In[31:16];
        if (MEM_Byte)
            load_val = {{24{MEM_SignExtend & load_byte[7]}}, load_byte};
        else if (MEM_Half)
            load_val = {{16{MEM_SignExtend & load_half[15]}}, load_half};
        else
            load_val = dmem.DataMem_In;
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DATAMEM_LLSC_EN
        ll_d     = ll_q;
        lladdr_d = lladdr_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = ACCESS;
                    read_d  = MEM_MemRead;
                    write_d = MEM_MemWrite;
                    we_d    = MEM_MemWrite ? lane_we : 4'b0000;
                    wdata_d = lane_wdata;
                end
            end
            ACCESS: begin
                if (dmem.DataMem_Ready) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    we_d    = '0;
                    if (read_q)
                        rdata_d = load_val;
                    if (write_q & MEM_LLSC)
                        rdata_d = 32'd1;
`ifdef DATAMEM_LLSC_EN
                    if (read_q & MEM_LLSC) begin
                        ll_d     = 1'b1;
                        lladdr_d = MEM_Address[31:2];
                    end
                    if (write_q & ll_match)
                        ll_d = 1'b0;
`endif
                end
            end
            DONE: begin
                if (!IF_Stall)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            we_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DATAMEM_LLSC_EN
            ll_q     <= 1'b0;
            lladdr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DATAMEM_LLSC_EN
            ll_q     <= ll_d;
            lladdr_q <= lladdr_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed scoreboard bench for data_mem_controller; the bench acts as the data memory.
module tb_data_mem_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] MEM_Address, MEM_WriteData;
    logic        MEM_MemRead, MEM_MemWrite, MEM_Byte, MEM_Half, MEM_SignExtend, MEM_LLSC;
    logic        IF_Stall;
    logic        M_Stall_Controller, M_Exc_AdEL, M_Exc_AdES;
    logic [31:0] M_ReadData;

    data_mem_controller_if dmem ();

    data_mem_controller dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .MEM_Address        (MEM_Address),
        .MEM_WriteData      (MEM_WriteData),
        .MEM_MemRead        (MEM_MemRead),
        .MEM_MemWrite       (MEM_MemWrite),
        .MEM_Byte           (MEM_Byte),
        .MEM_Half           (MEM_Half),
        .MEM_SignExtend     (MEM_SignExtend),
        .MEM_LLSC           (MEM_LLSC),
        .IF_Stall           (IF_Stall),
        .M_Stall_Controller (M_Stall_Controller),
        .M_ReadData         (M_ReadData),
        .M_Exc_AdEL         (M_Exc_AdEL),
        .M_Exc_AdES         (M_Exc_AdES),
        .dmem               (dmem.master)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    int unsigned r_stall, r_rdp, r_wrp;
    logic [3:0]  r_we;
    logic [31:0] r_wd, r_rd0;
    logic        r_adel, r_ades, r_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(tag, obs, e);
    endtask

    // Drive one request and act as memory until the controller releases the stall.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wd,
                              input logic rd, input logic wr, input logic bt,
                              input logic hf, input logic sx, input logic ll,
                              input int unsigned waits, input logic [31:0] mem);
        logic pr, pw, strobe;
        int unsigned sc;
        @(posedge clock); #1;
        MEM_Address = addr; MEM_WriteData = wd; MEM_MemRead = rd; MEM_MemWrite = wr;
        MEM_Byte = bt; MEM_Half = hf; MEM_SignExtend = sx; MEM_LLSC = ll;
        dmem.DataMem_In = mem; dmem.DataMem_Ready = 1'b0;
        pr = 1'b0; pw = 1'b0; sc = 0;
        r_stall = 0; r_rdp = 0; r_wrp = 0; r_we = '0; r_wd = '0; r_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (c == 0) begin
                r_adel = M_Exc_AdEL; r_ades = M_Exc_AdES; r_rd0 = M_ReadData;
            end
            if (dmem.DataMem_Read && !pr) r_rdp++;
            if (dmem.DataMem_Write && !pw) r_wrp++;
            pr = dmem.DataMem_Read; pw = dmem.DataMem_Write;
            strobe = dmem.DataMem_Read | dmem.DataMem_Write;
            if (strobe) begin
                r_we = dmem.DataMem_WriteEnable; r_wd = dmem.DataMem_WriteData; sc++;
            end
            dmem.DataMem_Ready = strobe && (sc > waits);
            if (!M_Stall_Controller) begin
                r_done = 1'b1;
                break;
            end
            r_stall++;
        end
        check("completed_in_budget", {31'b0, r_done}, 32'd1);
    endtask

    task automatic release_req(input string tag);
        @(posedge clock); #1;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_LLSC = 1'b0;
        MEM_Byte = 1'b0; MEM_Half = 1'b0; MEM_SignExtend = 1'b0;
        dmem.DataMem_Ready = 1'b0;
        @(negedge clock);
        check({tag, "_no_reissue"}, {30'b0, dmem.DataMem_Read, dmem.DataMem_Write}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; IF_Stall = 1'b0;
        MEM_Address = '0; MEM_WriteData = '0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        MEM_Byte = 1'b0; MEM_Half = 1'b0; MEM_SignExtend = 1'b0; MEM_LLSC = 1'b0;
        dmem.DataMem_In = '0; dmem.DataMem_Ready = 1'b0;
        #3;
        check("rst_stall", {31'b0, M_Stall_Controller}, 32'd0);
        check("rst_strobes", {30'b0, dmem.DataMem_Read, dmem.DataMem_Write}, 32'd0);
        check("rst_we", {28'b0, dmem.DataMem_WriteEnable}, 32'd0);
        check("rst_rdata", M_ReadData, 32'd0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;

        // LW, zero wait
        exp_q.push_back(32'hDEADBEEF);
        run_access(32'h100, '0, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        check("lw_stall", r_stall, 32'd2);
        check("lw_pulses", r_rdp, 32'd1);
        check("lw_addr", {2'b0, dmem.DataMem_Address}, 32'h40);
        check_pop("lw_rdata", M_ReadData);
        release_req("lw");

        // SB, 3 wait states
        run_access(32'h103, 32'h000000A5, 0, 1, 1, 0, 0, 0, 3, '0);
        check("sb_stall", r_stall, 32'd5);
        check("sb_we", {28'b0, r_we}, 32'h1);
        check("sb_wdata", r_wd, 32'hA5A5A5A5);
        check("sb_pulses", r_wrp, 32'd1);
        release_req("sb");

        // LH sign-extended, lower half
        exp_q.push_back(32'hFFFFF00D);
        run_access(32'h202, '0, 1, 0, 0, 1, 1, 0, 0, 32'h1234F00D);
        check_pop("lh_rdata", M_ReadData);
        release_req("lh");

        // LH misaligned
        run_access(32'h201, '0, 1, 0, 0, 1, 1, 0, 0, 32'h1234F00D);
        check("lh_mis_adel", {31'b0, r_adel}, 32'd1);
        check("lh_mis_stall", r_stall, 32'd0);
        check("lh_mis_pulses", r_rdp, 32'd0);
        release_req("lh_mis");

        // LBU byte 1
        exp_q.push_back(32'h000000AD);
        run_access(32'h101, '0, 1, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF);
        check("lbu_stall", r_stall, 32'd3);
        check_pop("lbu_rdata", M_ReadData);
        release_req("lbu");

        // SH to upper address half
        run_access(32'h202, 32'h0000BEEF, 0, 1, 0, 1, 0, 0, 0, '0);
        check("sh_we", {28'b0, r_we}, 32'h3);
        check("sh_wdata", r_wd, 32'hBEEFBEEF);
        release_req("sh");

        // SW misaligned
        run_access(32'h206, 32'h1, 0, 1, 0, 0, 0, 0, 0, '0);
        check("sw_mis_flags", {30'b0, r_adel, r_ades}, 32'd1);
        check("sw_mis_stall", r_stall, 32'd0);
        check("sw_mis_pulses", r_wrp, 32'd0);
        release_req("sw_mis");

        // Load finishing while the pipeline is frozen
        IF_Stall = 1'b1;
        exp_q.push_back(32'h11223344);
        run_access(32'h100, '0, 1, 0, 0, 0, 0, 0, 0, 32'h11223344);
        check("ifs_stall", r_stall, 32'd2);
        for (int i = 0; i < 4; i++) begin
            logic pr;
            pr = dmem.DataMem_Read;
            @(negedge clock);
            if (dmem.DataMem_Read && !pr) r_rdp++;
            check("ifs_hold_stall", {31'b0, M_Stall_Controller}, 32'd0);
        end
        check("ifs_pulses", r_rdp, 32'd1);
        check_pop("ifs_rdata", M_ReadData);
        @(posedge clock); #1;
        IF_Stall = 1'b0;
        release_req("ifs");

        // LL then SC to the same word
        exp_q.push_back(32'hCAFEF00D);
        run_access(32'h300, '0, 1, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D);
        check_pop("ll_rdata", M_ReadData);
        release_req("ll");
        exp_q.push_back(32'd1);
        run_access(32'h300, 32'h77, 0, 1, 0, 0, 0, 1, 0, '0);
        check("sc1_pulses", r_wrp, 32'd1);
        check("sc1_we", {28'b0, r_we}, 32'hF);
        check_pop("sc1_rdata", M_ReadData);
        release_req("sc1");
`ifdef DATAMEM_LLSC_EN
        exp_q.push_back(32'd0);
        run_access(32'h300, 32'h78, 0, 1, 0, 0, 0, 1, 0, '0);
        check("sc2_pulses", r_wrp, 32'd0);
        check("sc2_stall", r_stall, 32'd0);
        check_pop("sc2_rdata", r_rd0);
        release_req("sc2");
`else
        exp_q.push_back(32'd1);
        run_access(32'h300, 32'h78, 0, 1, 0, 0, 0, 1, 0, '0);
        check("sc2_pulses", r_wrp, 32'd1);
        check_pop("sc2_rdata", M_ReadData);
        release_req("sc2");
`endif

        // Reset in the middle of an access
        @(posedge clock); #1;
        MEM_Address = 32'h400; MEM_MemRead = 1'b1; dmem.DataMem_Ready = 1'b0;
        dmem.DataMem_In = 32'h55555555;
        @(negedge clock); @(negedge clock);
        check("rst_mid_access_read", {31'b0, dmem.DataMem_Read}, 32'd1);
        check("rst_mid_prev_rdata", M_ReadData, 32'd1);
        #1 dmem.DataMem_Ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_strobes", {30'b0, dmem.DataMem_Read, dmem.DataMem_Write}, 32'd0);
        check("rst_mid_rdata", M_ReadData, 32'd0);
        MEM_MemRead = 1'b0; dmem.DataMem_Ready = 1'b0;
        #1;
        check("rst_mid_stall", {31'b0, M_Stall_Controller}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_mid_idle", {30'b0, dmem.DataMem_Read, dmem.DataMem_Write}, 32'd0);
        check("rst_mid_rdata_after", M_ReadData, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
